// File: rtl/uart_link_ctrl.sv
// Link controller: arbitrates RX and user-load bytes into the FIFO and sequences FIFO pops into the UART TX.
// Build option: LINK_CTRL_AUTO_SEND_EN drains the FIFO continuously instead of one byte per send_pulse.
module uart_link_ctrl #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              ld_pulse,
  input  logic [7:0]        ld_data,
  input  logic              send_pulse,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_rd_data,
  input  logic              tx_busy,
  output logic              fifo_wr_en,
  output logic [7:0]        fifo_wr_data,
  output logic              fifo_rd_en,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    BUSY = 2'd3
  } tx_state_e;

  logic              rx_hold_v_q, ld_hold_v_q;
  logic [7:0]        rx_hold_q, ld_hold_q;
  logic              fifo_wr_en_q;
  logic [7:0]        fifo_wr_data_q;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q;

  logic              issue_rx, issue_ld, issue_any, issue_drop, ld_conflict;
  logic [7:0]        issue_byte;
  logic [1:0]        drops;
  logic [DROP_W:0]   drop_sum;

  tx_state_e         state_q;
  logic              fifo_rd_en_q, tx_start_q, busy_seen_q;
  logic [7:0]        tx_data_q;
  logic              trigger;

  // The RX hold always wins, so it is drained the cycle after every capture.
  assign issue_rx    = rx_hold_v_q;
  assign issue_ld    = ld_hold_v_q && !rx_hold_v_q;
  assign issue_any   = issue_rx || issue_ld;
  assign issue_byte  = issue_rx ? rx_hold_q : ld_hold_q;
  assign issue_drop  = issue_any && fifo_full;
  assign ld_conflict = ld_pulse && ld_hold_v_q && !issue_ld;
  assign drops       = {1'b0, issue_drop} + {1'b0, ld_conflict};

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(drops);
    drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hold_v_q    <= 1'b0;
      rx_hold_q      <= 8'h00;
      ld_hold_v_q    <= 1'b0;
      ld_hold_q      <= 8'h00;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= 8'h00;
      drop_cnt_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      fifo_wr_en_q <= issue_any && !fifo_full;
      if (issue_any && !fifo_full) begin
        fifo_wr_data_q <= issue_byte;
      end
      rx_hold_v_q <= rx_valid;
      if (rx_valid) begin
        rx_hold_q <= rx_data;
      end
      if (ld_pulse && !ld_conflict) begin
        ld_hold_v_q <= 1'b1;
        ld_hold_q   <= ld_data;
      end else if (issue_ld) begin
        ld_hold_v_q <= 1'b0;
      end
      drop_cnt_q <= drop_cnt_d;
      if (drops != 2'd0) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef LINK_CTRL_AUTO_SEND_EN
  logic unused_send_pulse;
  assign unused_send_pulse = send_pulse;
  assign trigger           = 1'b1;
`else
  assign trigger = send_pulse;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fifo_rd_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_seen_q  <= 1'b0;
    end else begin
      fifo_rd_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger && !fifo_empty) begin
            state_q      <= POP;
            fifo_rd_en_q <= 1'b1;
          end
        end
        POP: state_q <= LOAD;
        LOAD: begin
          tx_data_q   <= fifo_rd_data;
          tx_start_q  <= 1'b1;
          busy_seen_q <= 1'b0;
          state_q     <= BUSY;
        end
        BUSY: begin
          // tx_busy rises a cycle or two after tx_start, so wait for a full high-low cycle.
          if (tx_busy) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign fifo_rd_en   = fifo_rd_en_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign drop_cnt     = drop_cnt_q;
  assign overflow     = overflow_q;
  assign state        = state_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: FIFO and transmitter environment, queue-based reference model and directed vectors.
module tb_uart_link_ctrl;

  localparam int DROP_W = 3;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              ld_pulse = 1'b0;
  logic [7:0]        ld_data = 8'h00;
  logic              send_pulse = 1'b0;
  logic              fifo_full;
  logic              fifo_empty = 1'b1;
  logic [7:0]        fifo_rd_data = 8'h00;
  logic              tx_busy = 1'b0;
  logic              fifo_wr_en;
  logic [7:0]        fifo_wr_data;
  logic              fifo_rd_en;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;
  logic [1:0]        state;

  uart_link_ctrl #(.DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .ld_pulse(ld_pulse), .ld_data(ld_data),
    .send_pulse(send_pulse),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .tx_busy(tx_busy),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .tx_start(tx_start), .tx_data(tx_data),
    .drop_cnt(drop_cnt), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- environment: byte FIFO and transmitter ----------------
  logic       full_force = 1'b0;
  logic       fifo_cap = 1'b0;
  logic       flush_req = 1'b0;
  logic       preload_req = 1'b0;
  logic [7:0] preload_byte = 8'h00;
  logic [7:0] fq[$];
  int         bcnt = 0;

  assign fifo_full = full_force | fifo_cap;

  always @(posedge clk) begin
    logic [7:0] popped;
    if (flush_req) fq.delete();
    if (preload_req) fq.push_back(preload_byte);
    if (fifo_wr_en && !fifo_full) fq.push_back(fifo_wr_data);
    if (fifo_rd_en && fq.size() > 0) begin
      popped = fq.pop_front();
      fifo_rd_data <= popped;
    end
    fifo_empty <= (fq.size() == 0);
    fifo_cap   <= (fq.size() >= 16);
  end

  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      bcnt    <= 3;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic       is_ld;
    logic [7:0] b;
  } pend_t;

  pend_t pq[$];
  int    cyc = 0;
  logic  mvalid = 1'b0;
  int    m_wr_en = 0, m_wr_data = 0, m_drop = 0, m_ovf = 0;
  int    m_rd_en = 0, m_tx_start = 0, m_tx_data = 0, m_state = 0;
  logic  t_active = 1'b0, t_seen = 1'b0;
  int    t_acc = 0;
  logic  trig;

`ifdef LINK_CTRL_AUTO_SEND_EN
  assign trig = 1'b1;
`else
  assign trig = send_pulse;
`endif

  always @(posedge clk) begin
    int    nd;
    pend_t p;
    logic  has_ld;
    cyc++;
    mvalid = 1'b1;
    if (rst) begin
      pq.delete();
      m_wr_en = 0; m_drop = 0; m_ovf = 0;
      m_rd_en = 0; m_tx_start = 0; m_tx_data = 0; m_state = 0;
      t_active = 1'b0;
    end else begin
      // Pending bytes form a priority queue: RX bytes jump to the front, one byte leaves per cycle.
      nd = 0;
      m_wr_en = 0;
      if (pq.size() > 0) begin
        p = pq.pop_front();
        if (fifo_full) nd++;
        else begin
          m_wr_en   = 1;
          m_wr_data = int'(p.b);
        end
      end
      if (rx_valid) begin
        p.is_ld = 1'b0;
        p.b     = rx_data;
        pq.push_front(p);
      end
      if (ld_pulse) begin
        has_ld = 1'b0;
        foreach (pq[i]) if (pq[i].is_ld) has_ld = 1'b1;
        if (has_ld) nd++;
        else begin
          p.is_ld = 1'b1;
          p.b     = ld_data;
          pq.push_back(p);
        end
      end
      m_drop = (m_drop + nd > DMAX) ? DMAX : m_drop + nd;
      if (nd > 0) m_ovf = 1;

      // Transfer timeline relative to the accepting edge t_acc.
      if (!t_active) begin
        if (trig && !fifo_empty) begin
          t_active = 1'b1;
          t_acc    = cyc;
          t_seen   = 1'b0;
        end
      end else if (cyc >= t_acc + 3) begin
        if (tx_busy) t_seen = 1'b1;
        else if (t_seen) t_active = 1'b0;
      end
      if (t_active && cyc == t_acc + 2) m_tx_data = int'(fifo_rd_data);
      m_rd_en    = (t_active && cyc == t_acc) ? 1 : 0;
      m_tx_start = (t_active && cyc == t_acc + 2) ? 1 : 0;
      m_state    = !t_active ? 0 : (cyc == t_acc) ? 1 : (cyc == t_acc + 1) ? 2 : 3;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("wr_en", int'(fifo_wr_en), m_wr_en);
      if (m_wr_en != 0) chk("wr_data", int'(fifo_wr_data), m_wr_data);
      chk("rd_en", int'(fifo_rd_en), m_rd_en);
      chk("tx_start", int'(tx_start), m_tx_start);
      chk("tx_data", int'(tx_data), m_tx_data);
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("overflow", int'(overflow), m_ovf);
      chk("state", int'(state), m_state);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      tick();
      n++;
    end
    chk(nm, int'(state), s);
  endtask

  initial begin
    int n_starts;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_drop", int'(drop_cnt), 0);
    chk("reset_wr_en", int'(fifo_wr_en), 0);
    tick();

    // Single RX byte.
    rx_valid = 1'b1; rx_data = 8'h41;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("rx41_wr_en", int'(fifo_wr_en), 1);
    chk("rx41_data", int'(fifo_wr_data), 'h41);
    chk("rx41_drop", int'(drop_cnt), 0);
    tick();

    // Same-cycle collision: RX first, load byte one cycle later.
    rx_valid = 1'b1; rx_data = 8'h11; ld_pulse = 1'b1; ld_data = 8'h22;
    tick();
    rx_valid = 1'b0; ld_pulse = 1'b0;
    tick();
    chk("coll_first", int'(fifo_wr_data), 'h11);
    tick();
    chk("coll_second_en", int'(fifo_wr_en), 1);
    chk("coll_second", int'(fifo_wr_data), 'h22);
    chk("coll_nodrop", int'(drop_cnt), 0);
    tick();

    // Load into a full FIFO.
    full_force = 1'b1;
    ld_pulse = 1'b1; ld_data = 8'h55;
    tick();
    ld_pulse = 1'b0;
    tick();
    chk("full_no_wr", int'(fifo_wr_en), 0);
    chk("full_drop", int'(drop_cnt), 1);
    chk("full_ovf", int'(overflow), 1);
    full_force = 1'b0;
    tick();
    tick();
    chk("ovf_sticky", int'(overflow), 1);

    // Load pulse while the load hold is still waiting.
    rx_valid = 1'b1; rx_data = 8'h77; ld_pulse = 1'b1; ld_data = 8'h66;
    tick();
    rx_valid = 1'b0; ld_data = 8'h88;
    tick();
    ld_pulse = 1'b0;
    chk("hold_busy_rx", int'(fifo_wr_data), 'h77);
    chk("hold_busy_drop", int'(drop_cnt), 2);
    tick();
    chk("hold_kept_old", int'(fifo_wr_data), 'h66);

    // Two drops in one cycle, then saturation.
    full_force = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h01; ld_pulse = 1'b1; ld_data = 8'h02;
    tick();
    rx_valid = 1'b0; ld_data = 8'h03;
    tick();
    ld_pulse = 1'b0;
    chk("double_drop", int'(drop_cnt), 4);
    tick();
    chk("drop_after_ld", int'(drop_cnt), 5);
    for (int i = 0; i < 4; i++) begin
      ld_pulse = 1'b1; ld_data = 8'(i);
      tick();
    end
    ld_pulse = 1'b0;
    tick();
    tick();
    chk("drop_saturated", int'(drop_cnt), DMAX);
    full_force = 1'b0;
    tick();

    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();

`ifdef LINK_CTRL_AUTO_SEND_EN
    wait_state(0, 40, "auto_idle_before");
    n_starts = 0;
    for (int i = 0; i < 60; i++) begin
      preload_req  = (i < 3);
      preload_byte = 8'(8'hD1 + i);
      tick();
      if (tx_start) n_starts++;
    end
    preload_req = 1'b0;
    chk("auto_three_starts", n_starts, 3);
    chk("auto_drained", int'(fifo_empty), 1);
`else
    n_starts = 0;
    // Queue 0xA5, 0xB6 and send one byte.
    preload_req = 1'b1; preload_byte = 8'hA5;
    tick();
    preload_byte = 8'hB6;
    tick();
    preload_req = 1'b0;
    tick();
    send_pulse = 1'b1;
    tick();
    send_pulse = 1'b0;
    chk("send_rd_en", int'(fifo_rd_en), 1);
    tick();
    chk("send_load", int'(state), 2);
    tick();
    chk("send_tx_start", int'(tx_start), 1);
    chk("send_tx_data", int'(tx_data), 'hA5);
    send_pulse = 1'b1;
    tick();
    send_pulse = 1'b0;
    chk("busy_state", int'(state), 3);
    wait_state(0, 30, "back_to_idle");
    tick();
    chk("busy_send_ignored", int'(state), 0);
    chk("b6_still_queued", int'(fifo_empty), 0);

    send_pulse = 1'b1;
    tick();
    send_pulse = 1'b0;
    tick();
    tick();
    chk("second_tx_data", int'(tx_data), 'hB6);
    if (tx_start) n_starts++;
    chk("second_tx_start", n_starts, 1);
    wait_state(0, 30, "second_idle");

    // Send with an empty FIFO.
    send_pulse = 1'b1;
    tick();
    send_pulse = 1'b0;
    chk("empty_no_rd", int'(fifo_rd_en), 0);
    chk("empty_state", int'(state), 0);
    tick();
    chk("empty_state_hold", int'(state), 0);
`endif

    // Reset in the middle of a transfer.
    preload_req = 1'b1; preload_byte = 8'hC3;
    tick();
    preload_req = 1'b0;
    tick();
    send_pulse = 1'b1;
    tick();
    send_pulse = 1'b0;
    wait_state(3, 10, "reach_busy");
    rst = 1'b1;
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
